// File: rtl/sum_bist.sv
// Exhaustive built-in self-test for the 4-bit sum adder: sweeps all 256 operand
// pairs, compares the adder response to a reference and reports the result.
module sum_bist #(
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             x0,
  output logic             x1,
  output logic             x2,
  output logic             x3,
  output logic             y0,
  output logic             y1,
  output logic             y2,
  output logic             y3,
  input  logic             o0,
  input  logic             o1,
  input  logic             o2,
  input  logic             o3,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [3:0]       fail_x,
  output logic [3:0]       fail_y
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0]       SETTLE_L = 4'(SETTLE);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           state_q;
  logic [7:0]       idx_q;
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic             fail_valid_q;
  logic [3:0]       fail_x_q;
  logic [3:0]       fail_y_q;

  logic [4:0] ref_sum;
  logic [4:0] obs_sum;
  logic       mismatch;

  assign ref_sum  = {1'b0, idx_q[7:4]} + {1'b0, idx_q[3:0]};
  assign obs_sum  = {carry, o3, o2, o1, o0};
  assign mismatch = (ref_sum != obs_sum);

  // Saturating error count as it will stand after the current compare.
  always_comb begin
    err_d = err_q;
    if (mismatch && (err_q != ERR_MAX)) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_x_q     <= '0;
      fail_y_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx_q        <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_x_q     <= '0;
            fail_y_q     <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
            cnt_q        <= SETTLE_L;
            state_q      <= (SETTLE > 0) ? S_SETTLE : S_CHECK;
          end
        end
        S_SETTLE: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_q <= S_CHECK;
        end
        S_CHECK: begin
          err_q <= err_d;
          if (mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_x_q     <= idx_q[7:4];
            fail_y_q     <= idx_q[3:0];
          end
          if (idx_q == 8'hFF) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            idx_q   <= idx_q + 8'd1;
            cnt_q   <= SETTLE_L;
            state_q <= (SETTLE > 0) ? S_SETTLE : S_CHECK;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign {x3, x2, x1, x0} = idx_q[7:4];
  assign {y3, y2, y1, y0} = idx_q[3:0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_x     = fail_x_q;
  assign fail_y     = fail_y_q;

endmodule
